// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA pattern generator.
package vga_pkg;

  localparam int DEF_COLOR_W   = 8;
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_CELL_LOG2 = 5;
  localparam int DEF_BAR_W     = 16;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    CHECKER = 2'd1,
    RAMP    = 2'd2,
    MOVBAR  = 2'd3
  } pattern_e;

  // On/off per channel; expanded to full scale at the output stage.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t C_WHITE   = '{r: 1'b1, g: 1'b1, b: 1'b1};
  localparam rgb_t C_YELLOW  = '{r: 1'b1, g: 1'b1, b: 1'b0};
  localparam rgb_t C_CYAN    = '{r: 1'b0, g: 1'b1, b: 1'b1};
  localparam rgb_t C_GREEN   = '{r: 1'b0, g: 1'b1, b: 1'b0};
  localparam rgb_t C_MAGENTA = '{r: 1'b1, g: 1'b0, b: 1'b1};
  localparam rgb_t C_RED     = '{r: 1'b1, g: 1'b0, b: 1'b0};
  localparam rgb_t C_BLUE    = '{r: 1'b0, g: 1'b0, b: 1'b1};
  localparam rgb_t C_BLACK   = '{r: 1'b0, g: 1'b0, b: 1'b0};

  function automatic rgb_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      3'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// DAC-side video bus: colour channels plus sync/blank controls.
interface vga_pattern_gen_if #(
  parameter int COLOR_W = 8
);
  logic [COLOR_W-1:0] R;
  logic [COLOR_W-1:0] G;
  logic [COLOR_W-1:0] B;
  logic               HSync;
  logic               VSync;
  logic               Blank;
  logic               Sync;

  modport master (output R, G, B, HSync, VSync, Blank, Sync);
  modport slave  (input  R, G, B, HSync, VSync, Blank, Sync);
endinterface

// File: rtl/vga_timing.sv
// Raster counters with combinational sync, visible and frame-wrap decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk_VGA,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          visible_o,
  output logic          frame_wrap_o
);

  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_VGA or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o      = h_cnt_q;
  assign v_cnt_o      = v_cnt_q;
  assign hsync_o      = (h_cnt_q >= HS_BEG && h_cnt_q <= HS_END) ? H_POL : ~H_POL;
  assign vsync_o      = (v_cnt_q >= VS_BEG && v_cnt_q <= VS_END) ? V_POL : ~V_POL;
  assign visible_o    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign frame_wrap_o = h_last && v_last;

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA test-pattern generator: four patterns, frame-synchronous select.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int CELL_LOG2 = DEF_CELL_LOG2,
  parameter int BAR_W     = DEF_BAR_W
) (
  input  logic                clk_VGA,
  input  logic                rst_n,
  input  logic [1:0]          channel,
  vga_pattern_gen_if.master   dac,
  output logic                frame_start,
  output logic [1:0]          active_ch
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int XW1     = XW + 1;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SEG     = H_ACTIVE / 8;

  localparam logic [XW-1:0] BAR_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW:0]   HA_X     = XW1'(H_ACTIVE);
  localparam logic [XW:0]   BARW_X   = XW1'(BAR_W);
  localparam logic [HW-1:0] CX_MASK  = HW'(1 << CELL_LOG2);
  localparam logic [VW-1:0] CY_MASK  = VW'(1 << CELL_LOG2);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          hsync, vsync, visible, frame_wrap;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL), .HW(HW), .VW(VW)
  ) u_timing (
    .clk_VGA      (clk_VGA),
    .rst_n        (rst_n),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .visible_o    (visible),
    .frame_wrap_o (frame_wrap)
  );

  pattern_e           ach_q, ach_d, ach_out_q;
  logic [XW-1:0]      bar_x_q, bar_x_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic               hs_q, vs_q, blank_q, fs_q;

  logic [COLOR_W-1:0] ramp;
  logic [2:0]         bar_idx;
  logic [XW:0]        hx, bx, dx;
  logic               cx, cy, in_bar;
  rgb_t               pix;

  // Keep the top COLOR_W bits of x; narrow rasters are zero-extended.
  if (XW >= COLOR_W) begin : g_ramp_msb
    assign ramp = h_cnt[XW-1 -: COLOR_W];
  end else begin : g_ramp_ext
    assign ramp = COLOR_W'(h_cnt[XW-1:0]);
  end

  assign cx = |(h_cnt & CX_MASK);
  assign cy = |(v_cnt & CY_MASK);

  // Select and bar position only move at the frame wrap so a frame is never torn.
  always_comb begin
    ach_d   = frame_wrap ? pattern_e'(channel) : ach_q;
    bar_x_d = bar_x_q;
    if (frame_wrap) bar_x_d = (bar_x_q == BAR_LAST) ? '0 : bar_x_q + 1'b1;
  end

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++)
      if (h_cnt >= HW'(k * SEG)) bar_idx = 3'(k);

    // Distance right of the bar start, modulo the line width, so the bar wraps.
    hx     = {1'b0, h_cnt[XW-1:0]};
    bx     = {1'b0, bar_x_q};
    dx     = (hx >= bx) ? hx - bx : hx + HA_X - bx;
    in_bar = (dx < BARW_X);

    case (ach_q)
      BARS:    pix = bar_color(bar_idx);
      CHECKER: pix = (cx ^ cy) ? C_BLACK : C_WHITE;
      MOVBAR:  pix = in_bar ? C_WHITE : C_BLUE;
      default: pix = C_BLACK;
    endcase

    r_d = {COLOR_W{pix.r}};
    g_d = {COLOR_W{pix.g}};
    b_d = {COLOR_W{pix.b}};
    if (ach_q == RAMP) begin
      r_d = ramp;
      g_d = ramp;
      b_d = ramp;
    end
    if (!visible) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge clk_VGA or negedge rst_n) begin
    if (!rst_n) begin
      ach_q     <= BARS;
      bar_x_q   <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= ~H_POL;
      vs_q      <= ~V_POL;
      blank_q   <= 1'b0;
      fs_q      <= 1'b0;
      ach_out_q <= BARS;
    end else begin
      ach_q     <= ach_d;
      bar_x_q   <= bar_x_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hsync;
      vs_q      <= vsync;
      blank_q   <= visible;
      fs_q      <= (h_cnt == '0) && (v_cnt == '0);
      ach_out_q <= ach_q;
    end
  end

  assign dac.R       = r_q;
  assign dac.G       = g_q;
  assign dac.B       = b_q;
  assign dac.HSync   = hs_q;
  assign dac.VSync   = vs_q;
  assign dac.Blank   = blank_q;
  assign dac.Sync    = 1'b0;
  assign frame_start = fs_q;
  assign active_ch   = ach_out_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench: a raster model derived from the cycle count predicts every output pixel.
module tb_vga_pattern_gen;

  localparam int  CW   = 8;
  localparam int  HA   = 16, HF = 2, HS = 3, HB = 2;
  localparam int  VA   = 8,  VF = 1, VS = 1, VB = 1;
  localparam bit  HPOL = 1'b1;
  localparam bit  VPOL = 1'b0;
  localparam int  CELL = 2;
  localparam int  BARW = 4;
  localparam int  HT   = HA + HF + HS + HB;
  localparam int  VT   = VA + VF + VS + VB;
  localparam int  FR   = HT * VT;
  localparam int  XW   = $clog2(HA);

  logic       clk_VGA = 1'b0;
  logic       rst_n;
  logic [1:0] channel;
  logic       frame_start;
  logic [1:0] active_ch;

  vga_pattern_gen_if #(.COLOR_W(CW)) dac ();

  vga_pattern_gen #(
    .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HPOL), .V_POL(VPOL), .CELL_LOG2(CELL), .BAR_W(BARW)
  ) dut (
    .clk_VGA     (clk_VGA),
    .rst_n       (rst_n),
    .channel     (channel),
    .dac         (dac),
    .frame_start (frame_start),
    .active_ch   (active_ch)
  );

  always #5 clk_VGA = ~clk_VGA;

  typedef struct packed {
    logic [CW-1:0] r, g, b;
    logic hs, vs, blank, sync, fs;
    logic [1:0] ach;
  } obs_t;

  typedef struct {
    int   t;
    obs_t o;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // white, yellow, cyan, green, magenta, red, blue, black as {r,g,b}
  logic [2:0] pal [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  function automatic obs_t observe();
    obs_t o;
    o.r = dac.R; o.g = dac.G; o.b = dac.B;
    o.hs = dac.HSync; o.vs = dac.VSync; o.blank = dac.Blank; o.sync = dac.Sync;
    o.fs = frame_start; o.ach = active_ch;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = !HPOL;
    o.vs = !VPOL;
    return o;
  endfunction

  function automatic obs_t model(int t, int ch);
    obs_t o;
    int x, y, bar, idx, v;
    logic [2:0] c;
    logic [CW-1:0] full;
    full = '1;
    x   = t % HT;
    y   = (t / HT) % VT;
    bar = (t / FR) % HA;
    o       = '0;
    o.hs    = (x >= HA + HF && x < HA + HF + HS) ? HPOL : !HPOL;
    o.vs    = (y >= VA + VF && y < VA + VF + VS) ? VPOL : !VPOL;
    o.blank = (x < HA) && (y < VA);
    o.fs    = (x == 0) && (y == 0);
    o.ach   = 2'(ch);
    if (o.blank) begin
      c = 3'b000;
      case (ch)
        0: begin
          idx = x / (HA / 8);
          if (idx > 7) idx = 7;
          c = pal[idx];
        end
        1: c = ((((x >> CELL) ^ (y >> CELL)) & 1) == 0) ? 3'b111 : 3'b000;
        3: c = (((x - bar + HA) % HA) < BARW) ? 3'b111 : 3'b001;
        default: c = 3'b000;
      endcase
      o.r = c[2] ? full : '0;
      o.g = c[1] ? full : '0;
      o.b = c[0] ? full : '0;
      if (ch == 2) begin
        v = (XW >= CW) ? (x >> (XW - CW)) : x;
        o.r = CW'(v); o.g = CW'(v); o.b = CW'(v);
      end
    end
    return o;
  endfunction

  task automatic compare(input string tag, input int t, input obs_t got, input obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got R=%h G=%h B=%h hs=%b vs=%b blank=%b sync=%b fs=%b ch=%0d expected R=%h G=%h B=%h hs=%b vs=%b blank=%b sync=%b fs=%b ch=%0d",
               tag, t, got.r, got.g, got.b, got.hs, got.vs, got.blank, got.sync, got.fs, got.ach,
               exp.r, exp.g, exp.b, exp.hs, exp.vs, exp.blank, exp.sync, exp.fs, exp.ach);
    end
  endtask

  // Reference model: t counts edges since reset release; channel is latched at each frame's last edge.
  initial begin
    int t_m, cur_ch;
    exp_t e;
    t_m = 0;
    cur_ch = 0;
    forever begin
      @(posedge clk_VGA or negedge rst_n);
      if (!rst_n) begin
        t_m = 0;
        cur_ch = 0;
        q.delete();
      end else begin
        e.t = t_m;
        e.o = model(t_m, cur_ch);
        q.push_back(e);
        if (t_m % FR == FR - 1) cur_ch = channel;
        t_m++;
      end
    end
  end

  // Monitor: every output cycle is compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_VGA);
      if (!rst_n) compare("reset_hold", -1, observe(), reset_obs());
      else if (q.size() > 0) begin
        e = q.pop_front();
        compare("pixel", e.t, observe(), e.o);
      end
    end
  end

  task automatic run(input int ncyc);
    int f;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_VGA);
      #2;
      f = c / FR;
      if ((f >= 1 && f <= 3) || (f >= 12 && f <= 17)) channel = 2'd3;
      else if ($urandom_range(0, 49) == 0) channel = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    channel = 2'd0;
    repeat (3) @(posedge clk_VGA);
    #2;
    rst_n = 1'b1;
    run(20 * FR + 5 * HT + 7);
    // Reset lands mid-line, mid-frame, between clock edges.
    rst_n = 1'b0;
    #1;
    compare("async_reset", -1, observe(), reset_obs());
    repeat (2) @(posedge clk_VGA);
    #2;
    channel = 2'd0;
    rst_n   = 1'b1;
    run(22 * FR);
    @(negedge clk_VGA);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
